baby_vga_scan_timing: RTL

// - Raster timing generator for the 32x16 one-bit "baby VGA" display, ~640x480@60Hz from the 64 MHz project clock.
// - Sits directly upstream of the framebuffer and pixel output stage.
// - Produces the logical column/row indices, sync, blank, a frame counter, a line-start strobe and the vblank interrupt.
// - All outputs are registered.

---
 rtl/baby_vga_pkg.sv | 36 +++
 rtl/baby_vga_line_fsm.sv | 104 ++++++++++
 rtl/baby_vga_scan_timing.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/baby_vga_pkg.sv
// Shared timing constants and types for the 32x16 one-bit baby VGA raster.
package baby_vga_pkg;

  // Horizontal timing, in clk cycles (column width is (clk_div+1)*COL_MULT).
  localparam int COL_MULT = 5;
  localparam int H_FP     = 41;
  localparam int H_SYNC   = 244;
  localparam int H_BP     = 149;

  // Vertical timing, in scanlines.
  localparam int LINES_PER_ROW = 30;
  localparam int V_FP          = 10;
  localparam int V_SYNC        = 2;
  localparam int V_BP          = 33;

  // Logical display geometry.
  localparam int NUM_COLS = 32;
  localparam int NUM_ROWS = 16;

  localparam int ACTIVE_LINES = LINES_PER_ROW * NUM_ROWS;
  localparam int TOTAL_LINES  = ACTIVE_LINES + V_FP + V_SYNC + V_BP;

  // Horizontal phase of the current scanline.
  typedef enum logic [1:0] {
    HS_ACTIVE,
    HS_FP,
    HS_SYNC,
    HS_BP
  } h_state_t;

  // Cycles per logical column for a given width select; 16*5=80 fits 7 bits.
  function automatic logic [6:0] col_period(input logic [3:0] div, input int mult);
    return 7'((int'(div) + 1) * mult);
  endfunction

endpackage

// File: rtl/baby_vga_line_fsm.sv
// Horizontal line sequencer: ACTIVE -> FP -> SYNC -> BP with the per-column
// and per-phase cycle counters. Column width is latched on entry to ACTIVE.
module baby_vga_line_fsm
  import baby_vga_pkg::*;
#(
  parameter int MULT        = COL_MULT,
  parameter int FP_CYCLES   = H_FP,
  parameter int SYNC_CYCLES = H_SYNC,
  parameter int BP_CYCLES   = H_BP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] clk_div,
  output h_state_t   h_state,
  output logic       col_tick,
  output logic       end_of_line
);

  localparam logic [7:0] FP_LAST   = 8'(FP_CYCLES - 1);
  localparam logic [7:0] SYNC_LAST = 8'(SYNC_CYCLES - 1);
  localparam logic [7:0] BP_LAST   = 8'(BP_CYCLES - 1);
  localparam logic [4:0] LAST_COL  = 5'(NUM_COLS - 1);

  h_state_t   state_reg;
  logic [7:0] cyc_reg;
  logic [4:0] col_reg;
  logic [6:0] period_reg;

  logic col_last;
  logic line_last;

  // Column completion and end-of-line decode from the current counters.
  always_comb begin
    col_last  = 1'b0;
    line_last = 1'b0;
    if (state_reg == HS_ACTIVE && cyc_reg == ({1'b0, period_reg} - 8'd1)) begin
      col_last = 1'b1;
    end
    if (state_reg == HS_BP && cyc_reg == BP_LAST) begin
      line_last = 1'b1;
    end
  end

  assign h_state     = state_reg;
  assign col_tick    = col_last;
  assign end_of_line = line_last;

  // Phase sequencing; clk_div is only looked at when a new line begins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= HS_ACTIVE;
      cyc_reg    <= '0;
      col_reg    <= '0;
      period_reg <= col_period(clk_div, MULT);
    end else begin
      case (state_reg)
        HS_ACTIVE: begin
          if (col_last) begin
            cyc_reg <= '0;
            if (col_reg == LAST_COL) begin
              col_reg   <= '0;
              state_reg <= HS_FP;
            end else begin
              col_reg <= col_reg + 5'd1;
            end
          end else begin
            cyc_reg <= cyc_reg + 8'd1;
          end
        end
        HS_FP: begin
          if (cyc_reg == FP_LAST) begin
            cyc_reg   <= '0;
            state_reg <= HS_SYNC;
          end else begin
            cyc_reg <= cyc_reg + 8'd1;
          end
        end
        HS_SYNC: begin
          if (cyc_reg == SYNC_LAST) begin
            cyc_reg   <= '0;
            state_reg <= HS_BP;
          end else begin
            cyc_reg <= cyc_reg + 8'd1;
          end
        end
        HS_BP: begin
          if (line_last) begin
            cyc_reg    <= '0;
            state_reg  <= HS_ACTIVE;
            period_reg <= col_period(clk_div, MULT);
          end else begin
            cyc_reg <= cyc_reg + 8'd1;
          end
        end
        default: begin
          cyc_reg   <= '0;
          col_reg   <= '0;
          state_reg <= HS_ACTIVE;
        end
      endcase
    end
  end

endmodule

// File: rtl/baby_vga_scan_timing.sv
// Raster timing generator for the 32x16 baby VGA display. The horizontal
// sequencer lives in baby_vga_line_fsm; this level tracks lines, rows, frames
// and the vblank interrupt. Every output is a register describing the raster
// position of the previous cycle.
module baby_vga_scan_timing #(
  parameter int COL_MULT      = baby_vga_pkg::COL_MULT,
  parameter int H_FP          = baby_vga_pkg::H_FP,
  parameter int H_SYNC        = baby_vga_pkg::H_SYNC,
  parameter int H_BP          = baby_vga_pkg::H_BP,
  parameter int LINES_PER_ROW = baby_vga_pkg::LINES_PER_ROW,
  parameter int V_FP          = baby_vga_pkg::V_FP,
  parameter int V_SYNC        = baby_vga_pkg::V_SYNC,
  parameter int V_BP          = baby_vga_pkg::V_BP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cli,
  input  logic [3:0] clk_div,
  output logic [4:0] x_pos,
  output logic [3:0] y_pos,
  output logic       hsync,
  output logic       vsync,
  output logic       blank,
  output logic [2:0] counter,
  output logic       line_start,
  output logic       interrupt
);

  import baby_vga_pkg::*;

  localparam int ACT_LINES = LINES_PER_ROW * NUM_ROWS;
  localparam int TOT_LINES = ACT_LINES + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] ACT_L     = 10'(ACT_LINES);
  localparam logic [9:0] LAST_L    = 10'(TOT_LINES - 1);
  localparam logic [9:0] VS_START  = 10'(ACT_LINES + V_FP);
  localparam logic [9:0] VS_END    = 10'(ACT_LINES + V_FP + V_SYNC);
  localparam logic [4:0] SUB_LAST  = 5'(LINES_PER_ROW - 1);
  localparam logic [3:0] LAST_ROW  = 4'(NUM_ROWS - 1);

  h_state_t h_state;
  logic     col_tick;
  logic     end_of_line;

  baby_vga_line_fsm #(
    .MULT        (COL_MULT),
    .FP_CYCLES   (H_FP),
    .SYNC_CYCLES (H_SYNC),
    .BP_CYCLES   (H_BP)
  ) u_line_fsm (
    .clk         (clk),
    .rst         (rst),
    .clk_div     (clk_div),
    .h_state     (h_state),
    .col_tick    (col_tick),
    .end_of_line (end_of_line)
  );

  // Raster position state.
  logic [4:0] col_reg;
  logic [9:0] line_reg;
  logic [4:0] sub_reg;
  logic [3:0] row_reg;
  logic [2:0] frame_reg;
  logic       line_first_reg;

  // Output registers.
  logic [4:0] x_reg;
  logic [3:0] y_reg;
  logic       hsync_reg;
  logic       vsync_reg;
  logic       blank_reg;
  logic [2:0] counter_reg;
  logic       line_start_reg;
  logic       interrupt_reg;

  logic visible;
  logic in_vsync;

  // Position decode for the current cycle.
  always_comb begin
    visible  = (h_state == HS_ACTIVE) && (line_reg < ACT_L);
    in_vsync = (line_reg >= VS_START) && (line_reg < VS_END);
  end

  // Column index advances on each completed column and wraps after column 31,
  // which is exactly when the line FSM leaves ACTIVE.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_reg <= '0;
    end else if (col_tick) begin
      col_reg <= col_reg + 5'd1;
    end
  end

  // Line, row-within-frame and frame bookkeeping; the row uses a sub-counter
  // instead of dividing the line number. Row saturates through vblank.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_reg       <= '0;
      sub_reg        <= '0;
      row_reg        <= '0;
      frame_reg      <= '0;
      line_first_reg <= 1'b1;
    end else begin
      line_first_reg <= end_of_line;
      if (end_of_line) begin
        if (line_reg == LAST_L) begin
          line_reg  <= '0;
          sub_reg   <= '0;
          row_reg   <= '0;
          frame_reg <= frame_reg + 3'd1;
        end else begin
          line_reg <= line_reg + 10'd1;
          if (line_reg < ACT_L) begin
            if (sub_reg == SUB_LAST) begin
              sub_reg <= '0;
              if (row_reg != LAST_ROW) begin
                row_reg <= row_reg + 4'd1;
              end
            end else begin
              sub_reg <= sub_reg + 5'd1;
            end
          end
        end
      end
    end
  end

  // Registered video timing outputs; line_start fires on the cycle blank falls.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg          <= '0;
      y_reg          <= '0;
      hsync_reg      <= 1'b1;
      vsync_reg      <= 1'b1;
      blank_reg      <= 1'b1;
      counter_reg    <= '0;
      line_start_reg <= 1'b0;
    end else begin
      x_reg          <= visible ? col_reg : 5'd0;
      y_reg          <= row_reg;
      hsync_reg      <= (h_state != HS_SYNC);
      vsync_reg      <= ~in_vsync;
      blank_reg      <= ~visible;
      counter_reg    <= frame_reg;
      line_start_reg <= visible & blank_reg;
    end
  end

  // Sticky vblank interrupt; a set on the first cycle of the first blank line
  // beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      interrupt_reg <= 1'b0;
    end else if (line_first_reg && line_reg == ACT_L) begin
      interrupt_reg <= 1'b1;
    end else if (cli) begin
      interrupt_reg <= 1'b0;
    end
  end

  assign x_pos      = x_reg;
  assign y_pos      = y_reg;
  assign hsync      = hsync_reg;
  assign vsync      = vsync_reg;
  assign blank      = blank_reg;
  assign counter    = counter_reg;
  assign line_start = line_start_reg;
  assign interrupt  = interrupt_reg;

endmodule
